decoder_seq: RTL
================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL provide the parameter N, default 3, which sets the select width; the output width is 2**N.
REQ-002 The block SHALL provide the parameter DWELL, default 4, which sets the cycles each code is held in scan mode; DWELL is at least 1.
REQ-003 The block SHALL provide the parameter WRAP, default 1: value 1 makes scan wrap from 2**N-1 to 0; value 0 makes scan stop after 2**N-1.
REQ-004 The block SHALL provide the parameter ACTIVE_LOW, default 0: value 1 inverts every bit of d.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port en, input, 1 bit: global enable; when low, the block freezes.
REQ-008 Port mode, input, 1 bit: 0 = direct decode, 1 = scan.
REQ-009 Port s, input, N bits: select / scan start index.
REQ-010 Port s_valid, input, 1 bit: s is valid this cycle.
REQ-011 Port s_ready, output, 1 bit: the block accepts s this cycle.
REQ-012 Port d, output, 2**N bits: registered one-hot decode, polarity per ACTIVE_LOW.
REQ-013 Port d_valid, output, 1 bit: d carries a fresh or active code.
REQ-014 Port idx, output, N bits: the index currently driven on d.
REQ-015 Port done, output, 1 bit: one-cycle pulse when a non-wrapping scan completes.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-017 s_ready SHALL equal en AND (state == IDLE); a transfer occurs only when s_valid and s_ready are both high.
REQ-018 IDLE with mode=0: a transfer SHALL set, one cycle later, d = 1<<s (active-high form), idx = s and d_valid = 1 for exactly one cycle; d and idx then hold; latency is 1 and one transfer per cycle is sustained.
REQ-019 IDLE with mode=1: a transfer SHALL load idx = s, d = 1<<s, d_valid = 1, clear the dwell count and enter SCAN on the next cycle.
REQ-020 SCAN SHALL keep d_valid = 1; after DWELL cycles at one index, idx SHALL increment and d SHALL follow in the same cycle.
REQ-021 With WRAP=1, idx SHALL wrap from 2**N-1 to 0 and scanning continues; with WRAP=0, expiry at 2**N-1 SHALL enter DONE, pulse done for one cycle, hold d, and drop d_valid.
REQ-022 mode=0 sampled in SCAN or DONE SHALL move to IDLE on the next edge, with d = 0 (active-high form), d_valid = 0 and idx held.
REQ-023 en=0 SHALL freeze state, idx, d and the dwell count, force d_valid = 0 and s_ready = 0, and suppress done; scanning resumes from the frozen point when en returns high.
REQ-024 Simultaneous events SHALL follow the priority rst > en=0 > mode=0 exit > dwell advance.
REQ-025 DWELL=1 SHALL advance idx on every cycle; the dwell counter SHALL be clog2(DWELL)+1 bits wide with no overflow.
REQ-026 ACTIVE_LOW SHALL invert only the d port; idx, d_valid and done are unaffected.

Reset
REQ-027 rst high on a clock edge SHALL set state IDLE, idx 0, dwell 0, d_valid 0 and done 0, and d to all-0 (all-1 when ACTIVE_LOW=1); s_ready follows as 1 when en=1.
REQ-028 Reset during SCAN or DONE SHALL abort scanning with no done pulse.

Structure
REQ-029 The shared package decoder_pkg SHALL hold the state enum (IDLE, SCAN, DONE) and the mode constants MODE_DIRECT=0 and MODE_SCAN=1.
REQ-030 Dwell timing SHALL live in one sub-module, dwell_counter, with inputs clear and tick, parameter DWELL, and output expire.
REQ-031 All outputs SHALL be registered; no combinational path from s to d is allowed.

Verification (N=3, DWELL=4 unless noted)
REQ-032 Reset then mode=0, send s = 0..7 on consecutive cycles -> d = 0x01..0x80 one cycle later, d_valid high 8 cycles, idx = 0..7.
REQ-033 mode=1, s=6, WRAP=1 -> d = 0x40 for 4 cycles, then 0x80 for 4, then 0x01 (wrap), with d_valid high throughout.
REQ-034 WRAP=0, start s=6 -> after 8 cycles done pulses once, d holds 0x80, d_valid = 0; mode=0 -> IDLE, d = 0x00.
REQ-035 Scan at idx=2 with dwell count 1, en low 5 cycles -> d frozen at 0x04 with d_valid = 0; en high -> 3 more cycles at 0x04, then 0x08.
REQ-036 rst asserted mid-scan together with mode=0 and en=0 -> next cycle d = 0x00, idx = 0, d_valid = 0, no done pulse; repeat with ACTIVE_LOW=1 -> d = 0xFF.
REQ-037 DWELL=1, start s=0, WRAP=1 -> idx = 0,1,...,7,0 on consecutive cycles.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the scanning decoder.
// Imported by decoder_seq and its dwell counter.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Counter width able to hold DWELL-1 with one spare bit of headroom.
    function automatic int dwell_width(input int dwell);
        return $clog2(dwell) + 1;
    endfunction

endpackage

// File: rtl/decoder_seq_dwell_counter.sv
// Counts cycles spent on one scan index.
// expire marks the tick that completes a full dwell.
module dwell_counter
    import decoder_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CW = dwell_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    assign expire = tick && (count == LAST);

    // Advance on tick, restart after a full dwell or on clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            if (expire) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_seq.sv
// One-hot decoder with direct and timed-scan modes.
// d, idx, d_valid and done are all registered.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int WRAP       = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    s,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [2**N-1:0] d,
    output logic            d_valid,
    output logic [N-1:0]    idx,
    output logic            done
);

    localparam int W = 2**N;
    localparam logic [W-1:0] POL = {W{(ACTIVE_LOW != 0)}};
    localparam logic [N-1:0] LAST = '1;

    state_t       state;
    logic         xfer;
    logic         load_scan;
    logic         scan_run;
    logic         expire;
    logic [N-1:0] idx_nxt;

    // Port-polarity one-hot code for an index.
    function automatic logic [W-1:0] dec(input logic [N-1:0] i);
        return POL ^ (W'(1) << i);
    endfunction

    assign s_ready   = en && (state == IDLE);
    assign xfer      = s_valid && s_ready;
    assign load_scan = xfer && (mode == MODE_SCAN);
    assign scan_run  = en && (state == SCAN) && (mode == MODE_SCAN);
    assign idx_nxt   = idx + 1'b1;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (load_scan),
        .tick   (scan_run),
        .expire (expire)
    );

    // Control FSM with registered outputs; en low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            d       <= POL;
            d_valid <= 1'b0;
            done    <= 1'b0;
        end else if (!en) begin
            d_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    d_valid <= xfer;
                    if (xfer) begin
                        idx <= s;
                        d   <= dec(s);
                        if (mode == MODE_SCAN) begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        state   <= IDLE;
                        d       <= POL;
                        d_valid <= 1'b0;
                    end else begin
                        d_valid <= 1'b1;
                        if (expire) begin
                            if (idx == LAST && WRAP == 0) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                d_valid <= 1'b0;
                            end else begin
                                idx <= idx_nxt;
                                d   <= dec(idx_nxt);
                            end
                        end
                    end
                end
                DONE: begin
                    d_valid <= 1'b0;
                    if (mode == MODE_DIRECT) begin
                        state <= IDLE;
                        d     <= POL;
                    end
                end
                default: begin
                    state   <= IDLE;
                    d_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
